// File: rtl/store_merge_unit.sv
// Store merge unit: turns byte/halfword/word stores into whole-word memory
// writes. Sub-word stores read the target word, splice in the new lane(s)
// and write it back; word stores go straight to the write cycle. Faulting
// stores (misaligned or illegal size) complete with err and never write.
module store_merge_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic              mem_we
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [2:0] SelByte = 3'b000;
  localparam logic [2:0] SelHalf = 3'b001;
  localparam logic [2:0] SelWord = 3'b010;

  logic [1:0]        state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              err_q, err_d;
  logic              fault;
  logic [31:0]       merged;

  // Fault decode on the live request; only meaningful in the accept cycle.
  always_comb begin
    unique case (sel)
      SelByte: fault = 1'b0;
      SelHalf: fault = addr[0];
      SelWord: fault = (addr[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  // Splice the latched store data into the word currently read from memory.
  always_comb begin
    merged = mem_rdata;
    if (sel_q == SelHalf) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Next-state and latch control.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          sel_d   = sel;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = fault;
          if (fault)                state_d = StDone;
          else if (sel == SelWord)  state_d = StWrite;
          else                      state_d = StRead;
        end
      end
      StRead: begin
        merge_d = merged;
        state_d = StWrite;
      end
      StWrite: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State and latched operands; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registers so reset clears them immediately.
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StDone) & err_q;
  assign mem_we    = (state_q == StWrite);
  assign mem_addr  = {2'b00, addr_q[ADDR_W-1:2]};
  assign mem_wdata = (sel_q == SelWord) ? wdata_q : merge_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: a byte-addressed reference memory predicts the
// word each store leaves behind; a monitor checks every done/mem_we event.
module tb_store_merge_unit;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic [2:0]        sel = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic              busy, done, err, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata, mem_wdata;

  store_merge_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT, plus the byte-level reference model.
  logic [31:0] mem [0:4095];
  logic [7:0]  ref_b [0:4095];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic [2:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    int                c0;
  } item_t;
  item_t sb_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_b[widx*4+3], ref_b[widx*4+2], ref_b[widx*4+1], ref_b[widx*4]};
  endfunction

  function automatic bit is_fault(input logic [2:0] s, input logic [ADDR_W-1:0] a);
    int ai = int'(a);
    if (s == 3'd0) return 1'b0;
    if (s == 3'd1) return (ai % 2) != 0;
    if (s == 3'd2) return (ai % 4) != 0;
    return 1'b1;
  endfunction

  // Monitor: pops the expected store on done and checks result and timing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (sb_q.size() == 0) check("we_without_op", 32'd1, 32'd0);
        else begin
          check("we_addr", 32'(mem_addr), 32'(int'(sb_q[0].addr) / 4));
          we_cnt++;
        end
      end
      if (done) begin
        if (sb_q.size() == 0) check("done_without_op", 32'd1, 32'd0);
        else begin
          item_t it;
          bit f;
          int lat;
          int nb;
          it = sb_q.pop_front();
          f = is_fault(it.sel, it.addr);
          lat = f ? 1 : ((it.sel == 3'd2) ? 2 : 3);
          check("latency", 32'(cyc - it.c0), 32'(lat));
          check("err", {31'd0, err}, {31'd0, f});
          check("we_count", 32'(we_cnt), f ? 32'd0 : 32'd1);
          if (!f) begin
            nb = 1 << it.sel;
            for (int i = 0; i < nb; i++) ref_b[int'(it.addr) + i] = it.wdata[8*i +: 8];
          end
          check("word", mem[int'(it.addr) / 4], ref_word(int'(it.addr) / 4));
          we_cnt = 0;
        end
      end
    end
  end

  // Drive one cycle of inputs; record a store if the DUT will accept it.
  task automatic drive(input logic r, input logic [2:0] s, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d);
    item_t it;
    req = r; sel = s; addr = a; wdata = d;
    if (r && !busy) begin
      it.sel = s; it.addr = a; it.wdata = d; it.c0 = cyc;
      sb_q.push_back(it);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("timeout", 32'd1, 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] s, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wait_idle();
    drive(1'b1, s, a, d);
    req = 1'b0;
    wait_idle();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      mem[i] = w;
      if (i < 1024) for (int b = 0; b < 4; b++) ref_b[i*4+b] = w[8*b +: 8];
    end
    mem[2] = 32'h0000_0280;
    ref_b[8] = 8'h80; ref_b[9] = 8'h02; ref_b[10] = 8'h00; ref_b[11] = 8'h00;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed examples.
    issue(3'b000, 12'h009, 32'h0000_00AB);
    check("sb_word2", mem[2], 32'h0000_AB80);
    issue(3'b001, 12'h00A, 32'h0000_BEEF);
    check("sh_word2", mem[2], 32'hBEEF_AB80);
    issue(3'b010, 12'h01C, 32'hFFFF_FB00);
    check("sw_word7", mem[7], 32'hFFFF_FB00);
    issue(3'b001, 12'h00B, 32'h1234_5678);
    issue(3'b010, 12'h01E, 32'h1234_5678);
    issue(3'b011, 12'h008, 32'h1234_5678);
    check("fault_word2", mem[2], 32'hBEEF_AB80);

    // Random isolated stores.
    for (int k = 0; k < 40; k++) begin
      logic [2:0] s;
      s = (k % 8 == 7) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      issue(s, 12'($urandom_range(0, 127)), $urandom);
    end

    // req held high with changing operands: only IDLE samples are taken.
    wait_idle();
    for (int k = 0; k < 60; k++)
      drive(1'b1, 3'($urandom_range(0, 3)), 12'($urandom_range(0, 63)), $urandom);
    req = 1'b0;
    wait_idle();

    // Reset during READ of a byte store aborts without a write.
    w = ref_word(2);
    drive(1'b1, 3'b000, 12'h009, 32'h0000_005A);
    req = 1'b0;
    check("in_read_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    check("abort_addr", 32'(mem_addr), 32'd0);
    sb_q.delete();
    we_cnt = 0;
    repeat (2) @(negedge clk);
    check("abort_we", {31'd0, mem_we}, 32'd0);
    check("abort_word2", mem[2], w);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b000, 12'h009, 32'h0000_0077);
    check("after_reset_word2", mem[2], {w[31:16], 8'h77, w[7:0]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width; word index = addr[ADDR_W-1:2].
REQ-002 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  store request, sampled only in IDLE.
REQ-005 SHALL have port sel  input  3  store size (funct3): 000 sb, 001 sh, 010 sw; others illegal.
REQ-006 SHALL have port addr  input  ADDR_W  byte address of store.
REQ-007 SHALL have port wdata  input  32  store data, right-justified (sb uses [7:0], sh uses [15:0]).
REQ-008 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  valid with done; high = misaligned or illegal sel, no write performed.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word index to data memory, zero-extended {2'b00, addr[ADDR_W-1:2]}.
REQ-012 SHALL have port mem_rdata  input  32  combinational read data of word at mem_addr.
REQ-013 SHALL have port mem_wdata  output  32  merged word to write.
REQ-014 SHALL have port mem_we  output  1  memory write enable, memory writes on rising clk while high.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE, DONE in a registered state machine.
REQ-016 SHALL in IDLE with req=1 latch sel, addr, wdata into internal registers; no input is used after that edge.
REQ-017 SHALL transition IDLE->READ for legal aligned sb/sh, IDLE->WRITE for legal aligned sw, IDLE->DONE with err latched high for any fault.
REQ-018 SHALL fault when sel not in {000,001,010}, sh with addr[0]=1, or sw with addr[1:0]!=00; sb never misaligns.
REQ-019 SHALL in READ drive mem_addr from latched address and capture mem_rdata into a merge register; READ->WRITE unconditionally.
REQ-020 SHALL merge sb by replacing byte lane addr[1:0] (lane 0 = bits [7:0]) with wdata[7:0], other lanes from captured word.
REQ-021 SHALL merge sh by replacing halfword addr[1] (0 = [15:0], 1 = [31:16]) with wdata[15:0].
REQ-022 SHALL for sw drive mem_wdata = latched wdata, no read cycle.
REQ-023 SHALL assert mem_we only in WRITE, for exactly one cycle, decoded from state register; WRITE->DONE.
REQ-024 SHALL assert done for exactly one cycle in DONE, err held with it; DONE->IDLE.
REQ-025 SHALL give latency req-edge to done: sb/sh 3 cycles, sw 2 cycles, fault 1 cycle.
REQ-026 SHALL ignore req while busy; no queueing; a req held high in DONE is not accepted until IDLE next cycle.
REQ-027 SHALL drive mem_addr from latched address in READ and WRITE; value in IDLE/DONE is don't-care but stable.
REQ-028 SHALL accept back-to-back stores: req asserted in the IDLE cycle following DONE starts a new operation.

Reset
REQ-029 SHALL on rst_n low immediately force state IDLE, busy=0, done=0, err=0, mem_we=0, latched registers and mem_wdata 0.
REQ-030 SHALL on reset asserted mid-operation (READ/WRITE) abort with no further write; mem_we drops asynchronously.
REQ-031 SHALL resume accepting req on the first rising edge after rst_n returns high.

Verification
REQ-032 SHALL pass: word 2 = 0x00000280; sb addr 0x009 wdata 0x000000AB -> mem_we one cycle, word 2 = 0x0000AB80, done at +3 cycles, err=0.
REQ-033 SHALL pass: then sh addr 0x00A wdata 0x0000BEEF -> word 2 = 0xBEEFAB80, done at +3, err=0.
REQ-034 SHALL pass: sw addr 0x01C wdata 0xFFFFFB00 -> no READ, mem_addr=7, word 7 = 0xFFFFFB00, done at +2.
REQ-035 SHALL pass: sh addr 0x00B, sw addr 0x01E, sel=011 -> each done+err at +1, mem_we never high, memory unchanged.
REQ-036 SHALL pass: req held high continuously with changing wdata -> only IDLE-cycle samples written, one mem_we per operation.
REQ-037 SHALL pass: rst_n pulled low during READ of sb addr 0x009 -> mem_we never asserts, word 2 unchanged, outputs zero, next sb completes normally.
